// File: rtl/reactor_temp_conditioner.sv
// Conditions raw reactor probe samples into the qualified overheat level S:
// hysteresis thresholds, N-sample debounce, stale-sensor watchdog and fail-safe fault latch.
module reactor_temp_conditioner #(
    parameter int W       = 8,
    parameter int T_HI    = 200,
    parameter int T_LO    = 180,
    parameter int N_DEB   = 3,
    parameter int TIMEOUT = 1000
) (
    input  logic         CLOCK,
    input  logic         RESET,
    // TEMP_VALID is a one-cycle strobe with no back-pressure: TEMP is consumed
    // on every rising edge where TEMP_VALID is high, and ignored otherwise.
    input  logic [W-1:0] TEMP,
    input  logic         TEMP_VALID,
    output logic         S,
    output logic         SENSOR_FAULT,
    output logic [W-1:0] TEMP_LATCHED,
    output logic [2:0]   DEBUG_STATE
);

    localparam int DW = (N_DEB > 1) ? $clog2(N_DEB + 1) : 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    localparam logic [W-1:0]  HI_THR   = W'(T_HI);
    localparam logic [W-1:0]  LO_THR   = W'(T_LO);
    localparam logic [DW-1:0] DEB_ONE  = DW'(1);
    localparam logic [DW-1:0] DEB_GOAL = DW'(N_DEB);
    localparam logic [WW-1:0] WD_ONE   = WW'(1);
    localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);
    localparam logic [WW-1:0] WD_SAT   = {WW{1'b1}};

    typedef enum logic [2:0] {
        ST_NORMAL    = 3'd0,
        ST_PEND_HOT  = 3'd1,
        ST_HOT       = 3'd2,
        ST_PEND_COOL = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] deb_q, deb_d, deb_inc;
    logic [WW-1:0] wd_q, wd_d;
    logic          is_invalid, is_hot, is_cool;
    logic          take_sample, fault_now, s_d;

    always_comb begin
        is_invalid  = &TEMP;
        is_hot      = !is_invalid && (TEMP >= HI_THR);
        is_cool     = !is_invalid && (TEMP <= LO_THR);
        take_sample = TEMP_VALID && !is_invalid;
        deb_inc     = deb_q + DEB_ONE;
        // Timeout fires on the TIMEOUT-th consecutive edge without a strobe.
        fault_now   = (TEMP_VALID && is_invalid) || (!TEMP_VALID && (wd_q == WD_LAST));

        wd_d = wd_q;
        if (TEMP_VALID)
            wd_d = '0;
        else if (wd_q != WD_SAT)
            wd_d = wd_q + WD_ONE;

        state_d = state_q;
        deb_d   = deb_q;
        if (state_q == ST_FAULT) begin
            deb_d = '0;
        end else if (fault_now) begin
            state_d = ST_FAULT;
            deb_d   = '0;
        end else if (TEMP_VALID) begin
            case (state_q)
                ST_NORMAL: begin
                    deb_d = '0;
                    if (is_hot) begin
                        if (N_DEB == 1) begin
                            state_d = ST_HOT;
                        end else begin
                            state_d = ST_PEND_HOT;
                            deb_d   = DEB_ONE;
                        end
                    end
                end
                ST_PEND_HOT: begin
                    if (is_hot) begin
                        if (deb_inc == DEB_GOAL) begin
                            state_d = ST_HOT;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        state_d = ST_NORMAL;
                        deb_d   = '0;
                    end
                end
                ST_HOT: begin
                    deb_d = '0;
                    if (is_cool) begin
                        if (N_DEB == 1) begin
                            state_d = ST_NORMAL;
                        end else begin
                            state_d = ST_PEND_COOL;
                            deb_d   = DEB_ONE;
                        end
                    end
                end
                ST_PEND_COOL: begin
                    if (is_cool) begin
                        if (deb_inc == DEB_GOAL) begin
                            state_d = ST_NORMAL;
                            deb_d   = '0;
                        end else begin
                            deb_d = deb_inc;
                        end
                    end else begin
                        state_d = ST_HOT;
                        deb_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_FAULT;
                    deb_d   = '0;
                end
            endcase
        end

        s_d = (state_d == ST_HOT) || (state_d == ST_PEND_COOL) || (state_d == ST_FAULT);
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= ST_NORMAL;
            deb_q        <= '0;
            wd_q         <= '0;
            S            <= 1'b0;
            SENSOR_FAULT <= 1'b0;
            TEMP_LATCHED <= '0;
        end else begin
            state_q      <= state_d;
            deb_q        <= deb_d;
            wd_q         <= wd_d;
            S            <= s_d;
            SENSOR_FAULT <= (state_d == ST_FAULT);
            if (take_sample)
                TEMP_LATCHED <= TEMP;
        end
    end

    assign DEBUG_STATE = state_q;

endmodule

// File: tb/tb_reactor_temp_conditioner.sv
// Directed bench for reactor_temp_conditioner: debounce, hysteresis, band aborts,
// invalid-code and watchdog faults, and reset precedence.
module tb_reactor_temp_conditioner;

    localparam int W       = 8;
    localparam int TIMEOUT = 1000;

    localparam logic [2:0] ST_NORMAL    = 3'd0;
    localparam logic [2:0] ST_PEND_HOT  = 3'd1;
    localparam logic [2:0] ST_HOT       = 3'd2;
    localparam logic [2:0] ST_PEND_COOL = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    logic         clk;
    logic         rst;
    logic [W-1:0] temp;
    logic         temp_valid;
    logic         s;
    logic         sensor_fault;
    logic [W-1:0] temp_latched;
    logic [2:0]   debug_state;

    int n_assert = 0;
    int n_fail   = 0;

    reactor_temp_conditioner #(
        .W(W), .T_HI(200), .T_LO(180), .N_DEB(3), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLOCK        (clk),
        .RESET        (rst),
        .TEMP         (temp),
        .TEMP_VALID   (temp_valid),
        .S            (s),
        .SENSOR_FAULT (sensor_fault),
        .TEMP_LATCHED (temp_latched),
        .DEBUG_STATE  (debug_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; the next posedge accepts the sample, and we return
    // at the following negedge where the registered outputs are settled.
    task automatic strobe(input logic [W-1:0] t);
        temp       = t;
        temp_valid = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        temp       = '0;
        temp_valid = 1'b0;
        idle(2);
        rst = 1'b0;

        check("reset_s", s, 0);
        check("reset_fault", sensor_fault, 0);
        check("reset_latched", temp_latched, 0);
        check("reset_state", debug_state, ST_NORMAL);

        // Three hot strobes five cycles apart
        strobe(8'd210);
        check("hot1_s", s, 0);
        check("hot1_state", debug_state, ST_PEND_HOT);
        idle(4);
        strobe(8'd210);
        check("hot2_s", s, 0);
        idle(4);
        strobe(8'd210);
        check("hot3_s", s, 1);
        check("hot3_fault", sensor_fault, 0);
        check("hot3_latched", temp_latched, 210);
        check("hot3_state", debug_state, ST_HOT);

        // Band samples while HOT hold S
        for (int i = 0; i < 3; i++) begin
            strobe(8'd190);
            check("band_hold_s", s, 1);
        end
        check("band_latched", temp_latched, 190);

        // Cool run interrupted by a band sample
        strobe(8'd170);
        check("cool1_s", s, 1);
        check("cool1_state", debug_state, ST_PEND_COOL);
        strobe(8'd185);
        check("cool_abort_s", s, 1);
        check("cool_abort_state", debug_state, ST_HOT);
        strobe(8'd170);
        check("cool_a_s", s, 1);
        strobe(8'd170);
        check("cool_b_s", s, 1);
        strobe(8'd170);
        check("cool_c_s", s, 0);
        check("cool_c_state", debug_state, ST_NORMAL);

        // Cool sample aborts a pending hot transition
        strobe(8'd210);
        strobe(8'd210);
        check("pend_s", s, 0);
        strobe(8'd150);
        check("abort_s", s, 0);
        check("abort_state", debug_state, ST_NORMAL);
        strobe(8'd210);
        strobe(8'd210);
        check("rehot2_s", s, 0);
        strobe(8'd210);
        check("rehot3_s", s, 1);

        // Exact thresholds: 200 is hot, 180 is cool
        strobe(8'd180);
        strobe(8'd180);
        strobe(8'd180);
        check("lo_edge_s", s, 0);
        strobe(8'd200);
        strobe(8'd200);
        strobe(8'd200);
        check("hi_edge_s", s, 1);
        strobe(8'd181);
        strobe(8'd181);
        strobe(8'd181);
        check("band181_s", s, 1);
        strobe(8'd100);
        strobe(8'd100);
        strobe(8'd170);
        check("back_normal_s", s, 0);

        // Invalid probe code forces a sticky fault
        strobe(8'hFF);
        check("inv_s", s, 1);
        check("inv_fault", sensor_fault, 1);
        check("inv_latched", temp_latched, 170);
        check("inv_state", debug_state, ST_FAULT);
        for (int i = 0; i < 10; i++) strobe(8'd100);
        check("sticky_s", s, 1);
        check("sticky_fault", sensor_fault, 1);
        check("sticky_latched", temp_latched, 100);
        pulse_reset();
        check("clr_s", s, 0);
        check("clr_fault", sensor_fault, 0);
        check("clr_latched", temp_latched, 0);
        check("clr_state", debug_state, ST_NORMAL);

        // Watchdog: fault on the TIMEOUT-th idle edge
        strobe(8'd100);
        idle(TIMEOUT - 1);
        check("wd_before_s", s, 0);
        check("wd_before_fault", sensor_fault, 0);
        idle(1);
        check("wd_expire_s", s, 1);
        check("wd_expire_fault", sensor_fault, 1);
        pulse_reset();
        check("wd_clr_fault", sensor_fault, 0);

        // A strobe landing on the TIMEOUT-th edge keeps the sensor alive
        strobe(8'd100);
        idle(TIMEOUT - 1);
        strobe(8'd100);
        check("wd_rescue_fault", sensor_fault, 0);
        check("wd_rescue_s", s, 0);
        idle(5);
        check("wd_rescue_later", sensor_fault, 0);

        // Reset coincident with the third hot strobe wins
        strobe(8'd210);
        strobe(8'd210);
        temp       = 8'd210;
        temp_valid = 1'b1;
        rst        = 1'b1;
        @(negedge clk);
        temp_valid = 1'b0;
        rst        = 1'b0;
        check("rst_hot_s", s, 0);
        check("rst_hot_state", debug_state, ST_NORMAL);
        check("rst_hot_latched", temp_latched, 0);
        strobe(8'd210);
        strobe(8'd210);
        check("post_rst2_s", s, 0);
        strobe(8'd210);
        check("post_rst3_s", s, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
